fir_decim8: RTL and testbench
=============================

# fir_decim8

Decimating averager that sits directly downstream of the 8-tap-coefficient FIR stage. It consumes that stage's 8-bit `Dout` sample stream and sums each group of `DECIM` consecutive valid samples. It divides each sum by `DECIM` and buffers the results in a small show-ahead FIFO. Results leave through a valid/ready handshake, so a slower consumer can sit behind the filter without stalling it.

## Interface
- `DECIM`, 4: decimation factor. Power of two, range 2..16. `LOG2D` = log2(`DECIM`), computed locally.
- `FIFO_DEPTH`, 4: output FIFO entries. Power of two, range 2..16.
- `CLK` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset; clears all state immediately.
- `Din` input 8: sample from the FIR stage, unsigned.
- `din_valid` input 1: `Din` carries a sample this cycle.
- `clear` input 1: synchronous flush of accumulator, counter, FIFO and `overflow`.
- `Dout` output 8: head of the FIFO; reads 0 when the FIFO is empty.
- `dout_valid` output 1: FIFO is not empty.
- `dout_ready` input 1: consumer accepts `Dout` this cycle.
- `overflow` output 1: sticky flag; a result was dropped because the FIFO was full.
- `fifo_level` output 5: number of occupied FIFO entries, 0..`FIFO_DEPTH`.

## Operation
- Accumulator `acc` is 8+`LOG2D` bits wide; sample counter `cnt` runs 0..`DECIM`-1.
- Valid sample with `cnt` < `DECIM`-1: `acc` <= `acc`+`Din`, `cnt` <= `cnt`+1.
- Valid sample with `cnt` == `DECIM`-1 (group complete):
  - sum = `acc`+`Din`;
  - result = sum >> `LOG2D`, truncated;
  - result is pushed into the FIFO;
  - `acc` <= 0 and `cnt` <= 0 in the same cycle.
- Result width: the sum never exceeds 255·`DECIM`, so the result always fits in 8 bits. No saturation logic is needed.
- `din_valid` low: `acc` and `cnt` hold. Gaps between valid samples are legal at any point in a group.
- FIFO pop: occurs on a cycle where `dout_valid` and `dout_ready` are both high. `Dout` advances to the next entry on the following cycle.
- FIFO storage: circular buffer with read pointer, write pointer and a level counter. Pointers wrap modulo `FIFO_DEPTH`.
- Push while full without a pop in the same cycle: the result is dropped, `overflow` is set, and FIFO contents are unchanged.
- Push and pop in the same cycle: both take effect and `fifo_level` is unchanged. This holds when full (no overflow, no drop) and when holding exactly one entry.
- `dout_ready` while empty: ignored.
- `clear`: takes priority over `din_valid` and `dout_ready` in the same cycle. The sample presented with `clear` is discarded. After the edge, `acc`, `cnt`, both pointers, `fifo_level` and `overflow` are all 0.
- `overflow` clears only on `reset` or `clear`.

## Timing
- Reset values: `Dout` = 0, `dout_valid` = 0, `overflow` = 0, `fifo_level` = 0. Internal `acc`, `cnt` and pointers are also 0.
- Reset asserted mid-group or mid-drain: all state returns to reset values immediately, without waiting for a clock edge. The partial group is lost.
- Latency: when the `DECIM`-th sample is sampled on edge N, `dout_valid` is high and `Dout` shows the result after edge N, provided the FIFO was empty.
- Throughput: one sample accepted per cycle and one result popped per cycle. There is no backpressure on `Din`; the FIR stage never stalls.
- `fifo_level`, `dout_valid` and `overflow` are registered or derived directly from registered state. No combinational path runs from `dout_ready` to any output.

## Configuration
- `FIR_DECIM_ROUND_EN` defined: the result is round-half-up, (sum + `DECIM`/2) >> `LOG2D`. The intermediate sum is one bit wider so the addition cannot wrap. The maximum result is still 255.
- `FIR_DECIM_ROUND_EN` undefined: the result is plain truncation, sum >> `LOG2D`. The rounding adder is absent.

## Test plan
- `DECIM`=4, samples 10, 20, 30, 42 on consecutive cycles, `dout_ready`=1 → one result of 25, or 26 with `FIR_DECIM_ROUND_EN`. `dout_valid` is high for exactly one cycle, starting the cycle after the 42 edge.
- Same four samples with `din_valid` low for 3 cycles between each pair → same single result. No push occurs before the fourth valid sample.
- `dout_ready`=0, constant `Din`=8, 24 valid samples → 6 groups complete. `fifo_level` saturates at 4 and `overflow` rises on the 5th group. Raising `dout_ready` then drains exactly four results of 8.
- FIFO full, `dout_ready`=1 in the same cycle a group completes → `fifo_level` stays 4, `overflow` stays 0, and the new result appears last in the drain order.
- `clear` asserted after 2 of 4 samples, with 3 results queued → all queued results are gone and `dout_valid`=0 after the edge. The next 4 samples of 100 produce exactly one result of 100.
- `reset` pulsed asynchronously mid-group, away from any clock edge, with a non-empty FIFO → `Dout`, `dout_valid` and `fifo_level` read 0 before the next edge. Accumulation restarts from 0.

Source files
------------

// File: rtl/fir_decim8_if.sv
// Sample-in / result-out signal bundle for fir_decim8.
// The master side is the FIR stage plus the result consumer; the slave side is the averager.
interface fir_decim8_if;
   logic [7:0] Din;
   logic       din_valid;
   logic       clear;
   logic [7:0] Dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       overflow;
   logic [4:0] fifo_level;

   modport master (
      output Din, din_valid, clear, dout_ready,
      input  Dout, dout_valid, overflow, fifo_level
   );

   modport slave (
      input  Din, din_valid, clear, dout_ready,
      output Dout, dout_valid, overflow, fifo_level
   );
endinterface

// File: rtl/fir_decim8.sv
// Decimating averager: sums DECIM valid samples, divides by DECIM, queues results in a show-ahead FIFO.
// Define FIR_DECIM_ROUND_EN for round-half-up results instead of truncation.
module fir_decim8 #(
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input logic          CLK,
   input logic          reset,
   fir_decim8_if.slave  bus
);
   localparam int LOG2D = $clog2(DECIM);
   localparam int AW    = 8 + LOG2D;
   localparam int PW    = $clog2(FIFO_DEPTH);

   logic [AW-1:0]    acc;
   logic [LOG2D-1:0] cnt;
   logic [AW-1:0]    sum;
   logic [7:0]       result;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PW-1:0]    rptr;
   logic [PW-1:0]    wptr;
   logic [4:0]       level;
   logic             ovf;
   logic             grp_done;
   logic             full;
   logic             empty;
   logic             pop;
   logic             push;

   assign sum = acc + AW'(bus.Din);

`ifdef FIR_DECIM_ROUND_EN
   // One extra bit so the half-LSB bias cannot wrap a full-scale sum.
   logic [AW:0] sum_rnd;
   assign sum_rnd = {1'b0, sum} + (AW+1)'(DECIM / 2);
   assign result  = 8'(sum_rnd >> LOG2D);
`else
   assign result  = 8'(sum >> LOG2D);
`endif

   assign grp_done = bus.din_valid && (cnt == LOG2D'(DECIM - 1));
   assign full     = (level == 5'(FIFO_DEPTH));
   assign empty    = (level == 5'd0);
   assign pop      = !empty && bus.dout_ready;
   // A simultaneous pop frees the slot, so a full FIFO still accepts the result.
   assign push     = grp_done && (!full || pop);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         acc   <= '0;
         cnt   <= '0;
         rptr  <= '0;
         wptr  <= '0;
         level <= '0;
         ovf   <= 1'b0;
      end else if (bus.clear) begin
         acc   <= '0;
         cnt   <= '0;
         rptr  <= '0;
         wptr  <= '0;
         level <= '0;
         ovf   <= 1'b0;
      end else begin
         if (bus.din_valid) begin
            if (grp_done) begin
               acc <= '0;
               cnt <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + 1'b1;
            end
         end
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)
            level <= level + 5'd1;
         else if (pop && !push)
            level <= level - 5'd1;
         if (grp_done && full && !pop) ovf <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (push && !bus.clear && !reset) mem[wptr] <= result;
   end

   assign bus.Dout       = empty ? 8'd0 : mem[rptr];
   assign bus.dout_valid = !empty;
   assign bus.overflow   = ovf;
   assign bus.fifo_level = level;
endmodule

// File: tb/tb_fir_decim8.sv
// Scoreboard bench for fir_decim8: driver models groups and FIFO occupancy, monitor checks outputs and pops.
`timescale 1ns/1ps
module tb_fir_decim8;
   localparam int DECIM = 4;
   localparam int DEPTH = 4;

   logic CLK   = 1'b0;
   logic reset = 1'b1;

   fir_decim8_if bus();

   fir_decim8 #(.DECIM(DECIM), .FIFO_DEPTH(DEPTH)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   int sb[$];
   int grp[$];
   bit exp_ovf = 1'b0;

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model updates with what this edge will do.
   task automatic cyc(bit v, int d, bit rdy, bit clr = 1'b0);
      int  s;
      int  r;
      bit  will_pop;
      @(negedge CLK);
      #2;
      bus.din_valid  = v;
      bus.Din        = 8'(d);
      bus.dout_ready = rdy;
      bus.clear      = clr;
      if (clr) begin
         sb.delete();
         grp.delete();
         exp_ovf = 1'b0;
      end else if (v) begin
         grp.push_back(d & 255);
         if (grp.size() == DECIM) begin
            s = 0;
            foreach (grp[i]) s += grp[i];
`ifdef FIR_DECIM_ROUND_EN
            r = (s + DECIM / 2) / DECIM;
`else
            r = s / DECIM;
`endif
            grp.delete();
            will_pop = rdy && (sb.size() > 0);
            if (sb.size() == DEPTH && !will_pop)
               exp_ovf = 1'b1;
            else
               sb.push_back(r);
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge CLK);
      #2;
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b0;
      bus.clear      = 1'b0;
      reset = 1'b1;
      sb.delete();
      grp.delete();
      exp_ovf = 1'b0;
      #1;
      chk("rst_dout", int'(bus.Dout), 0);
      chk("rst_valid", int'(bus.dout_valid), 0);
      chk("rst_level", int'(bus.fifo_level), 0);
      #0.5;
      reset = 1'b0;
   endtask

   // Monitor: state checks mid-low-phase, then handshake pop once inputs are settled.
   initial begin
      forever begin
         @(negedge CLK);
         #1;
         chk("level", int'(bus.fifo_level), sb.size());
         chk("valid", int'(bus.dout_valid), int'(sb.size() > 0));
         chk("overflow", int'(bus.overflow), int'(exp_ovf));
         chk("dout_head", int'(bus.Dout), (sb.size() > 0) ? sb[0] : 0);
         #2;
         if (bus.dout_valid && bus.dout_ready && !bus.clear && !reset) begin
            if (sb.size() == 0)
               chk("pop_empty", sb.size(), 1);
            else
               chk("pop_data", int'(bus.Dout), sb.pop_front());
         end
      end
   end

   initial begin
      int smp[4];
      smp[0] = 10; smp[1] = 20; smp[2] = 30; smp[3] = 42;
      bus.din_valid  = 1'b0;
      bus.Din        = 8'd0;
      bus.dout_ready = 1'b0;
      bus.clear      = 1'b0;
      repeat (3) @(negedge CLK);
      #2 reset = 1'b0;

      // Back-to-back group.
      for (int i = 0; i < 4; i++) cyc(1'b1, smp[i], 1'b1);
      repeat (3) cyc(1'b0, 0, 1'b1);

      // Same group with gaps.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, smp[i], 1'b1);
         if (i < 3) repeat (3) cyc(1'b0, 0, 1'b1);
      end
      repeat (3) cyc(1'b0, 0, 1'b1);

      // Fill past full, overflow, then drain.
      for (int i = 0; i < 24; i++) cyc(1'b1, 8, 1'b0);
      repeat (6) cyc(1'b0, 0, 1'b1);
      cyc(1'b0, 0, 1'b0, 1'b1);

      // Full FIFO with a pop in the same cycle the next group completes.
      for (int i = 0; i < 16; i++) cyc(1'b1, 40 + 4 * (i / 4), 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 200, 1'b0);
      cyc(1'b1, 200, 1'b1);
      repeat (6) cyc(1'b0, 0, 1'b1);

      // Clear mid-group with queued results.
      for (int i = 0; i < 14; i++) cyc(1'b1, 60 + i, 1'b0);
      cyc(1'b1, 255, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 100, 1'b1);
      repeat (3) cyc(1'b0, 0, 1'b1);

      // Async reset mid-group with results queued.
      for (int i = 0; i < 10; i++) cyc(1'b1, 77, 1'b0);
      pulse_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 255, 1'b1);
      repeat (3) cyc(1'b0, 0, 1'b1);

      // Randomised traffic with occasional clear and reset.
      for (int i = 0; i < 3000; i++) begin
         if (i % 1000 == 999)
            pulse_reset();
         else
            cyc($urandom_range(0, 3) != 0,
                ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255)),
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 199) == 0);
      end
      repeat (8) cyc(1'b0, 0, 1'b1);

      @(negedge CLK);
      #4;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
